turn_signal_ctrl: RTL and testbench

Generates the blinking turn-left / turn-right lamp levels consumed by the light controller's turn inputs. Sources are the driver's raw turn-stalk and hazard switches. Debounces the switches, arbitrates left/right/hazard requests in a small FSM and times the blink with a half-period counter. Emits one-cycle click pulses for the piezo sounder on every lamp edge.

---
 rtl/car_light_pkg.sv | 43 ++++
 rtl/turn_signal_ctrl_if.sv | 32 +++
 rtl/switch_debouncer.sv | 51 +++++
 rtl/turn_signal_ctrl.sv | 167 ++++++++++++++++
 tb/tb_turn_signal_ctrl.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/car_light_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : car_light_pkg                                                 |
// | Purpose  : Shared definitions for the car lighting blocks: FSM state     |
// |            encodings, turn request encodings, default timing constants   |
// |            (shared with the light controller's PWM / tail-light timing)  |
// |            and the request decode helper.                                |
// | Ports    : none (package)                                                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package car_light_pkg;

   localparam int unsigned DEF_BLINK_HALF_CYC = 25_000_000;
   localparam int unsigned DEF_DEBOUNCE_CYC   = 500_000;
   localparam int unsigned DEF_TAP_CYC        = 25_000_000;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LEFT   = 3'd1,
      ST_RIGHT  = 3'd2,
      ST_HAZARD = 3'd3,
      ST_LANE3  = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      REQ_NONE  = 2'd0,
      REQ_LEFT  = 2'd1,
      REQ_RIGHT = 2'd2,
      REQ_HAZ   = 2'd3
   } req_t;

   // Hazard dominates; both stalk contacts closed at once is treated as a
   // mechanical fault and ignored.
   function automatic req_t decode_req(input logic l, input logic r, input logic h);
      if (h)           return REQ_HAZ;
      else if (l && r) return REQ_NONE;
      else if (l)      return REQ_LEFT;
      else if (r)      return REQ_RIGHT;
      else             return REQ_NONE;
   endfunction

endpackage
`default_nettype wire

// File: rtl/turn_signal_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : turn_signal_ctrl_if                                           |
// | Purpose  : Bundle of raw switch inputs and lamp/sounder outputs of the   |
// |            turn signal controller.                                       |
// | Signals  : sw_turn_left, sw_turn_right, sw_hazard : raw switches         |
// |            turn_left, turn_right : lamp levels, 1 = lit                  |
// |            blink_click : one-cycle pulse per lamp edge                   |
// |            hazard_active : high while in hazard mode                     |
// | Modports : master (switch side / observer), slave (controller)           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface turn_signal_ctrl_if;
   logic sw_turn_left;
   logic sw_turn_right;
   logic sw_hazard;
   logic turn_left;
   logic turn_right;
   logic blink_click;
   logic hazard_active;

   modport master (
      output sw_turn_left, sw_turn_right, sw_hazard,
      input  turn_left, turn_right, blink_click, hazard_active
   );

   modport slave (
      input  sw_turn_left, sw_turn_right, sw_hazard,
      output turn_left, turn_right, blink_click, hazard_active
   );
endinterface
`default_nettype wire

// File: rtl/switch_debouncer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : switch_debouncer                                              |
// | Purpose  : 2-flop synchroniser followed by a stable-count debouncer.     |
// |            The output flips only after the synchronised input has        |
// |            differed from it for DEBOUNCE_CYC consecutive cycles.         |
// | Ports    : clk, rst (sync, active-high), raw (async switch),             |
// |            level (debounced level)                                       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module switch_debouncer
   import car_light_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level
);

   // +1 keeps the width non-zero when DEBOUNCE_CYC is 1
   localparam int unsigned       CNT_W    = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] stable_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1      <= 1'b0;
         sync2      <= 1'b0;
         stable_cnt <= '0;
         level      <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         if (sync2 == level) begin
            stable_cnt <= '0;               // any bounce back restarts the count
         end else if (stable_cnt == CNT_LAST) begin
            level      <= sync2;
            stable_cnt <= '0;
         end else begin
            stable_cnt <= stable_cnt + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/turn_signal_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : turn_signal_ctrl                                              |
// | Purpose  : Debounces turn stalk / hazard switches, arbitrates requests   |
// |            in an FSM and blinks the turn lamps with a half-period        |
// |            counter. Emits a click pulse on every lamp edge.              |
// | Ports    : clk, rst (sync, active-high)                                  |
// |            bus : turn_signal_ctrl_if.slave (switches in, lamps out)      |
// | Options  : LANE_CHANGE_EN - short stalk tap gives 3 blinks (LANE3)       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module turn_signal_ctrl
   import car_light_pkg::*;
#(
   parameter int unsigned BLINK_HALF_CYC = DEF_BLINK_HALF_CYC,
   parameter int unsigned DEBOUNCE_CYC   = DEF_DEBOUNCE_CYC,
   parameter int unsigned TAP_CYC        = DEF_TAP_CYC
) (
   input  logic               clk,
   input  logic               rst,
   turn_signal_ctrl_if.slave  bus
);

   localparam int unsigned      CNT_W    = $clog2(BLINK_HALF_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_HALF_CYC - 1);

   logic deb_l, deb_r, deb_h;
   req_t req;

   switch_debouncer #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_left (
      .clk(clk), .rst(rst), .raw(bus.sw_turn_left), .level(deb_l));
   switch_debouncer #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_right (
      .clk(clk), .rst(rst), .raw(bus.sw_turn_right), .level(deb_r));
   switch_debouncer #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_hazard (
      .clk(clk), .rst(rst), .raw(bus.sw_hazard), .level(deb_h));

   assign req = decode_req(deb_l, deb_r, deb_h);

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             phase, phase_n;     // 1 = ON half-period
   logic             left_n, right_n, click_n;
   logic             wrap, changed;

`ifdef LANE_CHANGE_EN
   localparam int unsigned      TAP_W    = $clog2(TAP_CYC + 1);
   localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(TAP_CYC - 1);

   logic [TAP_W-1:0] tap_cnt, tap_cnt_n;       // cycles held, saturating
   logic [1:0]       on_halves, on_halves_n;   // completed ON halves in LANE3
   logic             lane_right, lane_right_n;
   logic             released, lane_done;

   assign released  = !deb_l && !deb_r && !deb_h;
   assign lane_done = (on_halves == 2'd2) && phase && wrap;
`endif

   assign wrap = (cnt == CNT_LAST);

   always_comb begin
      case (req)
         REQ_HAZ:   state_n = ST_HAZARD;
         REQ_LEFT:  state_n = ST_LEFT;
         REQ_RIGHT: state_n = ST_RIGHT;
         default:   state_n = ST_IDLE;
      endcase
`ifdef LANE_CHANGE_EN
      // A release after a short hold starts the 3-blink sequence; LANE3
      // then persists until its third ON half ends or a new request arrives.
      if (released) begin
         if ((state == ST_LEFT || state == ST_RIGHT) && (tap_cnt < TAP_LAST))
            state_n = ST_LANE3;
         else if (state == ST_LANE3 && !lane_done)
            state_n = ST_LANE3;
      end
`endif

      changed = (state_n != state);

      // Every state change restarts the blink at the beginning of an ON half
      if (changed) begin
         cnt_n   = '0;
         phase_n = 1'b1;
      end else if (wrap) begin
         cnt_n   = '0;
         phase_n = ~phase;
      end else begin
         cnt_n   = cnt + 1'b1;
         phase_n = phase;
      end

`ifdef LANE_CHANGE_EN
      lane_right_n = lane_right;
      if (changed && state_n == ST_LANE3)
         lane_right_n = (state == ST_RIGHT);

      on_halves_n = on_halves;
      if (changed)
         on_halves_n = 2'd0;
      else if (state == ST_LANE3 && phase && wrap)
         on_halves_n = on_halves + 2'd1;

      tap_cnt_n = tap_cnt;
      if (changed || !(state == ST_LEFT || state == ST_RIGHT))
         tap_cnt_n = '0;
      else if (tap_cnt != TAP_LAST)
         tap_cnt_n = tap_cnt + 1'b1;
`endif

      left_n  = 1'b0;
      right_n = 1'b0;
      case (state_n)
         ST_LEFT:   left_n  = phase_n;
         ST_RIGHT:  right_n = phase_n;
         ST_HAZARD: begin
            left_n  = phase_n;
            right_n = phase_n;
         end
`ifdef LANE_CHANGE_EN
         ST_LANE3: begin
            if (lane_right_n) right_n = phase_n;
            else              left_n  = phase_n;
         end
`endif
         default: ;
      endcase

      // Click coincides with the lamp edge it announces
      click_n = (left_n ^ bus.turn_left) | (right_n ^ bus.turn_right);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= ST_IDLE;
         cnt               <= '0;
         phase             <= 1'b1;
         bus.turn_left     <= 1'b0;
         bus.turn_right    <= 1'b0;
         bus.blink_click   <= 1'b0;
         bus.hazard_active <= 1'b0;
      end else begin
         state             <= state_n;
         cnt               <= cnt_n;
         phase             <= phase_n;
         bus.turn_left     <= left_n;
         bus.turn_right    <= right_n;
         bus.blink_click   <= click_n;
         bus.hazard_active <= (state_n == ST_HAZARD);
      end
   end

`ifdef LANE_CHANGE_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         tap_cnt    <= '0;
         on_halves  <= 2'd0;
         lane_right <= 1'b0;
      end else begin
         tap_cnt    <= tap_cnt_n;
         on_halves  <= on_halves_n;
         lane_right <= lane_right_n;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_turn_signal_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_turn_signal_ctrl                                           |
// | Purpose  : Self-checking bench for turn_signal_ctrl. A cycle model built |
// |            from time-since-entry arithmetic is compared to the DUT on    |
// |            every cycle; directed scenarios add literal expectations.     |
// | Ports    : none                                                          |
// | Options  : LANE_CHANGE_EN - must match the DUT build                     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_turn_signal_ctrl;

   localparam int BLINK_HALF_CYC = 4;
   localparam int DEBOUNCE_CYC   = 2;
   localparam int TAP_CYC        = 20;

   localparam int M_IDLE = 0, M_LEFT = 1, M_RIGHT = 2, M_HAZ = 3, M_LANE = 4;
   localparam int Q_NONE = 0, Q_LEFT = 1, Q_RIGHT = 2, Q_HAZ = 3;

`ifdef LANE_CHANGE_EN
   localparam int EXP_TAP_CLICKS = 8;
`else
   localparam int EXP_TAP_CLICKS = 2;
`endif

   logic clk;
   logic rst;
   turn_signal_ctrl_if bus ();

   turn_signal_ctrl #(
      .BLINK_HALF_CYC(BLINK_HALF_CYC),
      .DEBOUNCE_CYC  (DEBOUNCE_CYC),
      .TAP_CYC       (TAP_CYC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_cmp  = 0;
   int n_fail = 0;
   int n_clicks = 0;
   bit chk_en = 1'b0;

   // ---------------- behavioural model ----------------
   int   m_state, m_age, m_run, m_prev_q;
   bit   m_lane_right;
   logic m_s1 [3];
   logic m_s2 [3];
   logic m_deb [3];
   logic m_win [3][DEBOUNCE_CYC];
   logic m_l, m_r, m_click, m_haz;

   task automatic model_step();
      logic raw [3];
      int   q, ns;
      bit   on, nl, nr, all_diff;
      raw[0] = bus.sw_turn_left;
      raw[1] = bus.sw_turn_right;
      raw[2] = bus.sw_hazard;
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_deb[i] = 1'b0;
            for (int j = 0; j < DEBOUNCE_CYC; j++) m_win[i][j] = 1'b0;
         end
         m_state = M_IDLE; m_age = 0; m_run = 0; m_prev_q = Q_NONE;
         m_lane_right = 1'b0;
         m_l = 1'b0; m_r = 1'b0; m_click = 1'b0; m_haz = 1'b0;
      end else begin
         if (m_deb[2])                  q = Q_HAZ;
         else if (m_deb[0] && m_deb[1]) q = Q_NONE;
         else if (m_deb[0])             q = Q_LEFT;
         else if (m_deb[1])             q = Q_RIGHT;
         else                           q = Q_NONE;
         ns = (q == Q_HAZ) ? M_HAZ : (q == Q_LEFT) ? M_LEFT :
              (q == Q_RIGHT) ? M_RIGHT : M_IDLE;
`ifdef LANE_CHANGE_EN
         if (!m_deb[0] && !m_deb[1] && !m_deb[2]) begin
            if ((m_prev_q == Q_LEFT || m_prev_q == Q_RIGHT) && m_run < TAP_CYC)
               ns = M_LANE;
            else if (m_state == M_LANE && m_age != 5 * BLINK_HALF_CYC - 1)
               ns = M_LANE;
         end
         if (ns == M_LANE && m_state != M_LANE) m_lane_right = (m_state == M_RIGHT);
`endif
         if (q == m_prev_q) m_run++; else m_run = 1;
         m_prev_q = q;
         if (ns != m_state) m_age = 0; else m_age++;
         on = ((m_age / BLINK_HALF_CYC) % 2) == 0;
         nl = on && (ns == M_LEFT  || ns == M_HAZ || (ns == M_LANE && !m_lane_right));
         nr = on && (ns == M_RIGHT || ns == M_HAZ || (ns == M_LANE &&  m_lane_right));
         m_click = (nl != m_l) || (nr != m_r);
         m_l = nl; m_r = nr; m_haz = (ns == M_HAZ); m_state = ns;
         // debounced level flips once the last DEBOUNCE_CYC samples all disagree
         for (int i = 0; i < 3; i++) begin
            for (int j = DEBOUNCE_CYC - 1; j > 0; j--) m_win[i][j] = m_win[i][j-1];
            m_win[i][0] = m_s2[i];
            all_diff = 1'b1;
            for (int j = 0; j < DEBOUNCE_CYC; j++)
               if (m_win[i][j] == m_deb[i]) all_diff = 1'b0;
            if (all_diff) m_deb[i] = ~m_deb[i];
            m_s2[i] = m_s1[i];
            m_s1[i] = raw[i];
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // click pulses counted on the edge after they appear
   initial forever begin
      @(posedge clk);
      if (bus.blink_click === 1'b1) n_clicks++;
   end

   // per-cycle comparison against the model
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         n_cmp++;
         if ({bus.turn_left, bus.turn_right, bus.blink_click, bus.hazard_active} !==
             {m_l, m_r, m_click, m_haz}) begin
            n_fail++;
            $display("FAIL model_cmp t=%0t: got l/r/click/haz=%b%b%b%b required %b%b%b%b",
                     $time, bus.turn_left, bus.turn_right, bus.blink_click,
                     bus.hazard_active, m_l, m_r, m_click, m_haz);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string nm, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b required %b", nm, act, exp);
      end
   endtask

   task automatic check_int(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d", nm, act, exp);
      end
   endtask

   task automatic set_sw(input logic l, input logic r, input logic h);
      bus.sw_turn_left  = l;
      bus.sw_turn_right = r;
      bus.sw_hazard     = h;
   endtask

   initial begin
      int c0;
      // reset with every switch closed
      rst = 1'b1;
      set_sw(1'b1, 1'b1, 1'b1);
      cyc(1);
      chk_en = 1'b1;
      cyc(2);
      check("rst_left",   bus.turn_left,     1'b0);
      check("rst_right",  bus.turn_right,    1'b0);
      check("rst_click",  bus.blink_click,   1'b0);
      check("rst_hazard", bus.hazard_active, 1'b0);
      rst = 1'b0;
      cyc(4);
      check("haz_not_yet", bus.hazard_active, 1'b0);
      cyc(1);
      check("haz_on",       bus.hazard_active, 1'b1);
      check("haz_left_on",  bus.turn_left,     1'b1);
      check("haz_right_on", bus.turn_right,    1'b1);
      check("haz_click",    bus.blink_click,   1'b1);
      cyc(3);
      check("haz_left_4th", bus.turn_left, 1'b1);
      cyc(1);
      check("haz_left_off",  bus.turn_left,   1'b0);
      check("haz_click_off", bus.blink_click, 1'b1);
      set_sw(1'b0, 1'b0, 1'b0);
      cyc(12);

      // held left stalk
      set_sw(1'b1, 1'b0, 1'b0);
      cyc(5);
      check("left_on",    bus.turn_left,   1'b1);
      check("left_click", bus.blink_click, 1'b1);
      check("left_right", bus.turn_right,  1'b0);
      cyc(1);
      check("left_click_one", bus.blink_click, 1'b0);
      cyc(3);
      check("left_off",       bus.turn_left,   1'b0);
      check("left_click_off", bus.blink_click, 1'b1);

      // hazard pressed in cycle 2 of an OFF half
      cyc(1);
      set_sw(1'b1, 1'b0, 1'b1);
      cyc(4);
      check("lh_haz_pending", bus.hazard_active, 1'b0);
      cyc(1);
      check("lh_haz",   bus.hazard_active, 1'b1);
      check("lh_left",  bus.turn_left,     1'b1);
      check("lh_right", bus.turn_right,    1'b1);
      cyc(3);
      check("lh_right_4th", bus.turn_right, 1'b1);
      cyc(1);
      check("lh_right_off", bus.turn_right, 1'b0);
      set_sw(1'b1, 1'b0, 1'b0);
      cyc(5);
      check("resume_haz",   bus.hazard_active, 1'b0);
      check("resume_left",  bus.turn_left,     1'b1);
      check("resume_right", bus.turn_right,    1'b0);

      // reset in the middle of an ON half
      cyc(1);
      rst = 1'b1;
      cyc(1);
      check("midrst_left",  bus.turn_left,   1'b0);
      check("midrst_click", bus.blink_click, 1'b0);
      rst = 1'b0;
      set_sw(1'b0, 1'b0, 1'b0);
      cyc(12);

      // stalk conflict, then release right
      c0 = n_clicks;
      set_sw(1'b1, 1'b1, 1'b0);
      cyc(12);
      check("conf_left",  bus.turn_left,  1'b0);
      check("conf_right", bus.turn_right, 1'b0);
      check_int("conf_clicks", n_clicks - c0, 0);
      set_sw(1'b1, 1'b0, 1'b0);
      cyc(5);
      check("conf_rel_left",  bus.turn_left,  1'b1);
      check("conf_rel_right", bus.turn_right, 1'b0);
      set_sw(1'b0, 1'b0, 1'b0);
      cyc(12);

      // one-cycle glitch on the right stalk
      c0 = n_clicks;
      set_sw(1'b0, 1'b1, 1'b0);
      cyc(1);
      set_sw(1'b0, 1'b0, 1'b0);
      cyc(12);
      check("glitch_right", bus.turn_right, 1'b0);
      check_int("glitch_clicks", n_clicks - c0, 0);

      // 6-cycle tap of the left stalk
      c0 = n_clicks;
      set_sw(1'b1, 1'b0, 1'b0);
      cyc(6);
      set_sw(1'b0, 1'b0, 1'b0);
      cyc(40);
      check_int("tap_clicks", n_clicks - c0, EXP_TAP_CLICKS);
      check("tap_left_end", bus.turn_left, 1'b0);

      cyc(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
